fetch_sequencer: RTL and testbench

//   Master timing and instruction-fetch stage beside the PC stack. Runs the 8-phase machine cycle
//   (A1 A2 A3 M1 M2 X1 X2 X3) and drives cycle[2:0] to the PC stack and the rest of the core.

---
 rtl/fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_fetch_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: master timing and instruction-fetch stage.
//
// Runs the 8-phase machine cycle (A1 A2 A3 M1 M2 X1 X2 X3) and broadcasts the
// phase on `cycle`. It multiplexes the external 4-bit bus:
//   - the PC nibble during the A phases;
//   - nothing during the M phases;
//   - execute-unit data during the X phases.
// It latches OPR/OPA from ROM during M1/M2 and assembles two-word instructions.
//
// Ports
//   clock      in   single clock, posedge
//   reset      in   synchronous active-low reset
//   pc_word    in   PC nibble from the PC stack (A1-A3)
//   pc_enable  in   PC stack presents pc_word this cycle
//   exec_data  in   execute-unit bus data (X1-X3)
//   exec_oe    in   execute unit requests the bus (honoured in X1-X3 only)
//   data_in    in   sampled external bus (ROM data)
//   cycle      out  phase: 0=A1 .. 7=X3
//   sync       out  high while cycle == SYNC_PHASE
//   cm_rom     out  high in A3 and M2
//   data_out   out  bus drive value
//   data_oe    out  bus output enable
//   opr/opa    out  opcode / modifier nibbles of the current instruction
//   operand    out  second word of a two-word instruction
//   two_word   out  current instruction is two-word
//   exec_valid out  instruction complete, high during X1-X3
module fetch_sequencer #(
    parameter int unsigned DATA_W     = 4,
    parameter logic [2:0]  SYNC_PHASE = 3'h7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     pc_word,
    input  logic                  pc_enable,
    input  logic [DATA_W-1:0]     exec_data,
    input  logic                  exec_oe,
    input  logic [DATA_W-1:0]     data_in,
    output logic [2:0]            cycle,
    output logic                  sync,
    output logic                  cm_rom,
    output logic [DATA_W-1:0]     data_out,
    output logic                  data_oe,
    output logic [DATA_W-1:0]     opr,
    output logic [DATA_W-1:0]     opa,
    output logic [2*DATA_W-1:0]   operand,
    output logic                  two_word,
    output logic                  exec_valid
);

    localparam logic [2:0] PhA3 = 3'd2;
    localparam logic [2:0] PhM1 = 3'd3;
    localparam logic [2:0] PhM2 = 3'd4;
    localparam logic [2:0] PhX1 = 3'd5;
    localparam logic [2:0] PhX3 = 3'd7;

    logic [2:0]          cycle_q, cycle_d;
    logic [DATA_W-1:0]   opr_q, opa_q;
    logic [2*DATA_W-1:0] operand_q;
    logic                two_word_q;
    logic                pending_q;   // first word of a two-word instruction seen
    logic                complete_q;  // an instruction finished in this machine cycle
    logic                dbl_word;

    assign cycle_d = cycle_q + 3'd1;

    // JCN, FIM, JUN, JMS, ISZ take a second word; SRC (opr 2, opa[0]=1) does not.
    assign dbl_word = (opr_q == 4'h1) || ((opr_q == 4'h2) && !data_in[0]) ||
                      (opr_q == 4'h4) || (opr_q == 4'h5) || (opr_q == 4'h7);

    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_q    <= 3'd0;
            opr_q      <= '0;
            opa_q      <= '0;
            operand_q  <= '0;
            two_word_q <= 1'b0;
            pending_q  <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            if (cycle_q == PhM1) begin
                if (pending_q) begin
                    operand_q[2*DATA_W-1:DATA_W] <= data_in;
                end else begin
                    opr_q <= data_in;
                end
            end
            if (cycle_q == PhM2) begin
                if (pending_q) begin
                    operand_q[DATA_W-1:0] <= data_in;
                    pending_q             <= 1'b0;
                    complete_q            <= 1'b1;
                    two_word_q            <= 1'b1;
                end else begin
                    opa_q      <= data_in;
                    two_word_q <= 1'b0;
                    if (dbl_word) begin
                        pending_q  <= 1'b1;
                        complete_q <= 1'b0;
                    end else begin
                        complete_q <= 1'b1;
                    end
                end
            end
            if (cycle_q == PhX3) begin
                complete_q <= 1'b0;
            end
        end
    end

    // Bus mux: PC in A phases, idle in M phases, execute unit in X phases.
    always_comb begin
        data_out = '0;
        data_oe  = 1'b0;
        if (cycle_q <= PhA3) begin
            data_out = pc_word;
            data_oe  = pc_enable;
        end else if (cycle_q >= PhX1) begin
            data_oe  = exec_oe;
            data_out = exec_oe ? exec_data : '0;
        end
    end

    assign cycle      = cycle_q;
    assign sync       = (cycle_q == SYNC_PHASE);
    assign cm_rom     = (cycle_q == PhA3) || (cycle_q == PhM2);
    assign opr        = opr_q;
    assign opa        = opa_q;
    assign operand    = operand_q;
    assign two_word   = two_word_q;
    assign exec_valid = complete_q && (cycle_q >= PhX1);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: instruction-level reference model
// compared every cycle, directed scenarios with literal expectations, then
// randomized stimulus including random resets.
module tb_fetch_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] pc_word = '0;
    logic       pc_enable = 1'b0;
    logic [3:0] exec_data = '0;
    logic       exec_oe = 1'b0;
    logic [3:0] data_in = '0;
    logic [2:0] cycle;
    logic       sync, cm_rom, data_oe, two_word, exec_valid;
    logic [3:0] data_out, opr, opa;
    logic [7:0] operand;

    always #5 clock = ~clock;

    fetch_sequencer #(.DATA_W(4), .SYNC_PHASE(3'h7)) dut (
        .clock(clock), .reset(reset), .pc_word(pc_word), .pc_enable(pc_enable),
        .exec_data(exec_data), .exec_oe(exec_oe), .data_in(data_in),
        .cycle(cycle), .sync(sync), .cm_rom(cm_rom), .data_out(data_out),
        .data_oe(data_oe), .opr(opr), .opa(opa), .operand(operand),
        .two_word(two_word), .exec_valid(exec_valid)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (instruction level) ----------------
    int         m_phase = 0;
    logic [3:0] m_m1 = '0;        // nibble fetched in M1 of this machine cycle
    logic [3:0] m_opr = '0, m_opa = '0;
    logic [7:0] m_operand = '0;
    logic       m_two = 1'b0;
    logic       m_wait = 1'b0;    // waiting for the second word
    logic       m_done = 1'b0;    // an instruction completed in this machine cycle

    function automatic bit is_double(input logic [3:0] o, input logic [3:0] a);
        return (o == 4'h1) || (o == 4'h2 && a[0] == 1'b0) || (o == 4'h4) ||
               (o == 4'h5) || (o == 4'h7);
    endfunction

    task automatic model_edge();
        if (!reset) begin
            m_phase = 0; m_m1 = '0; m_opr = '0; m_opa = '0; m_operand = '0;
            m_two = 0; m_wait = 0; m_done = 0;
        end else begin
            if (m_phase == 3) m_m1 = data_in;
            if (m_phase == 4) begin
                if (m_wait) begin
                    m_operand = {m_m1, data_in};
                    m_two = 1; m_done = 1; m_wait = 0;
                end else begin
                    m_opr = m_m1; m_opa = data_in; m_two = 0;
                    m_wait = is_double(m_m1, data_in);
                    m_done = !m_wait;
                end
            end
            if (m_phase == 7) m_done = 0;
            m_phase = (m_phase + 1) % 8;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    // ---------------- per-cycle compare ----------------
    int e_out, e_oe, e_opr, e_operand;
    always @(negedge clock) begin
        if (cmp_en) begin
            if (m_phase < 3) begin
                e_out = pc_word; e_oe = pc_enable;
            end else if (m_phase < 5) begin
                e_out = 0; e_oe = 0;
            end else begin
                e_oe = exec_oe; e_out = exec_oe ? exec_data : 0;
            end
            // M1 results become visible one phase before the model's M2 update.
            e_opr     = (m_phase == 4 && !m_wait) ? m_m1 : m_opr;
            e_operand = (m_phase == 4 && m_wait) ? {m_m1, m_operand[3:0]} : m_operand;
            chk("cycle", cycle, m_phase);
            chk("sync", sync, m_phase == 7);
            chk("cm_rom", cm_rom, m_phase == 2 || m_phase == 4);
            chk("data_out", data_out, e_out);
            chk("data_oe", data_oe, e_oe);
            chk("opr", opr, e_opr);
            chk("opa", opa, m_opa);
            chk("operand", operand, e_operand);
            chk("two_word", two_word, m_two);
            chk("exec_valid", exec_valid, m_done && m_phase >= 5);
        end
    end

    // ---------------- directed machine-cycle driver ----------------
    logic [3:0] g_pc [3];
    int         g_xphase = 6;
    logic [3:0] g_xdata = 4'h9;
    logic [3:0] obs_out [8];
    logic       obs_oe [8];
    logic [2:0] obs_cyc [8];
    logic       obs_sync [8];
    logic       obs_cm [8];
    int         n_valid;
    logic [3:0] s_opr, s_opa;
    logic [7:0] s_operand;
    logic       s_two;

    // Called with the DUT in phase 0; returns with it in phase 0 again.
    task automatic run_cycle(input logic [3:0] m1, input logic [3:0] m2);
        n_valid = 0;
        for (int p = 0; p < 8; p++) begin
            if (p < 3) begin
                pc_word = g_pc[p]; pc_enable = 1'b1;
            end else begin
                pc_word = 4'($urandom); pc_enable = 1'($urandom);
            end
            exec_oe   = (p == g_xphase);
            exec_data = exec_oe ? g_xdata : 4'($urandom);
            data_in   = (p == 3) ? m1 : (p == 4) ? m2 : 4'($urandom);
            #1;
            obs_out[p] = data_out; obs_oe[p] = data_oe; obs_cyc[p] = cycle;
            obs_sync[p] = sync; obs_cm[p] = cm_rom;
            if (exec_valid) n_valid++;
            if (p == 5) begin
                s_opr = opr; s_opa = opa; s_operand = operand; s_two = two_word;
            end
            tick();
        end
    endtask

    initial begin
        g_pc[0] = 4'hA; g_pc[1] = 4'h5; g_pc[2] = 4'h3;
        reset = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b1;

        // Phase sequence, bus mux, LDM 4
        run_cycle(4'hD, 4'h4);
        for (int p = 0; p < 8; p++) begin
            chk("seq_cycle", obs_cyc[p], p);
            chk("seq_sync", obs_sync[p], p == 7);
            chk("seq_cm_rom", obs_cm[p], p == 2 || p == 4);
        end
        chk("pc_out0", obs_out[0], 4'hA);
        chk("pc_out1", obs_out[1], 4'h5);
        chk("pc_out2", obs_out[2], 4'h3);
        chk("pc_oe2", obs_oe[2], 1);
        chk("m1_oe", obs_oe[3], 0);
        chk("m2_oe", obs_oe[4], 0);
        chk("x2_out", obs_out[6], 4'h9);
        chk("x2_oe", obs_oe[6], 1);
        chk("ldm_valid", n_valid, 3);
        chk("ldm_opr", s_opr, 4'hD);
        chk("ldm_opa", s_opa, 4'h4);
        chk("ldm_two", s_two, 0);

        // JUN 0x123, with an exec_oe request in M1 that must be ignored
        g_xphase = 3;
        run_cycle(4'h4, 4'h1);
        chk("jun1_valid", n_valid, 0);
        chk("m1_req_oe", obs_oe[3], 0);
        chk("m1_req_out", obs_out[3], 0);
        run_cycle(4'h2, 4'h3);
        chk("jun2_valid", n_valid, 3);
        chk("jun_opr", s_opr, 4'h4);
        chk("jun_opa", s_opa, 4'h1);
        chk("jun_operand", s_operand, 8'h23);
        chk("jun_two", s_two, 1);

        // SRC single-word, FIM two-word
        g_xphase = -1;
        run_cycle(4'h2, 4'h1);
        chk("src_valid", n_valid, 3);
        chk("src_two", s_two, 0);
        run_cycle(4'h2, 4'h0);
        chk("fim1_valid", n_valid, 0);
        run_cycle(4'hF, 4'hF);
        chk("fim2_valid", n_valid, 3);
        chk("fim_operand", s_operand, 8'hFF);
        chk("fim_two", s_two, 1);
        chk("fim_opa", s_opa, 4'h0);

        // Reset at M2 of a JMS first word aborts the pending second word
        exec_oe = 1'b0;
        for (int p = 0; p < 4; p++) begin
            data_in = (p == 3) ? 4'h5 : 4'($urandom);
            tick();
        end
        data_in = 4'h0;
        reset = 1'b0;
        tick();
        chk("rst_cycle", cycle, 0);
        chk("rst_opr", opr, 0);
        reset = 1'b1;
        run_cycle(4'hD, 4'h4);
        chk("post_rst_valid", n_valid, 3);
        chk("post_rst_opr", s_opr, 4'hD);
        chk("post_rst_two", s_two, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            pc_word   = 4'($urandom);
            pc_enable = 1'($urandom);
            exec_data = 4'($urandom);
            exec_oe   = 1'($urandom);
            data_in   = 4'($urandom);
            reset     = ($urandom_range(0, 63) != 0);
            tick();
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
